// File: rtl/hex_display_driver.sv
// Multi-digit hex seven-segment driver: loadable value register, leading-zero blanking,
// global enable and per-digit blinking, with registered active-low segment outputs.
module hex_display_driver #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  ENABLE,
    input  logic                  BLANK_LZ,
    input  logic [DIGITS-1:0]     BLINK_MASK,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  BLINK_PHASE
);

    localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] value_q;
    logic [CW-1:0]       cnt_q;
    logic                phase_q;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   lz;
    logic                nz_seen;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Leading-zero mask: scan from the top digit until the first nonzero nibble.
    always_comb begin
        nz_seen = 1'b0;
        lz      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) nz_seen = 1'b1;
            lz[i] = BLANK_LZ && !nz_seen && (i != 0);
        end
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!ENABLE || (phase_q && BLINK_MASK[i]) || lz[i]) begin
                hex_d[7*i +: 7] = 7'h7F;
            end else begin
                hex_d[7*i +: 7] = decode(value_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            value_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hex_q   <= '1;
        end else begin
            if (LOAD) value_q <= VALUE;
            if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            hex_q <= hex_d;
        end
    end

    assign HEX         = hex_q;
    assign BLINK_PHASE = phase_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with DIGITS=6, BLINK_DIV=4.
module tb_hex_display_driver;

    localparam int unsigned DIGITS    = 6;
    localparam int unsigned BLINK_DIV = 4;

    logic                CLOCK_50 = 1'b0;
    logic                RESET = 1'b1;
    logic                LOAD = 1'b0;
    logic [4*DIGITS-1:0] VALUE = '0;
    logic                ENABLE = 1'b1;
    logic                BLANK_LZ = 1'b0;
    logic [DIGITS-1:0]   BLINK_MASK = '0;
    logic [7*DIGITS-1:0] HEX;
    logic                BLINK_PHASE;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;

    hex_display_driver #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .LOAD        (LOAD),
        .VALUE       (VALUE),
        .ENABLE      (ENABLE),
        .BLANK_LZ    (BLANK_LZ),
        .BLINK_MASK  (BLINK_MASK),
        .HEX         (HEX),
        .BLINK_PHASE (BLINK_PHASE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        logic [7*DIGITS-1:0] exp;
        RESET = 1'b1; LOAD = 1'b1; VALUE = 24'hABCDEF;
        ENABLE = 1'b1; BLANK_LZ = 1'b0; BLINK_MASK = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (HEX !== 42'h3FF_FFFF_FFFF || BLINK_PHASE !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got hex=%h phase=%b, want hex=3ffffffffff phase=0",
                         c, HEX, BLINK_PHASE);
            end
        end
        RESET = 1'b0; LOAD = 1'b0;
        tick();
        exp = {S0, S0, S0, S0, S0, S0};
        checks++;
        if (HEX !== exp) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", HEX, exp);
        end
    endtask

    task automatic test_decode();
        logic [23:0]         vals [3];
        logic [7*DIGITS-1:0] exps [3];
        vals[0] = 24'h012345;
        exps[0] = {S0, S1, S2, S3, 7'b0011001, S5};
        vals[1] = 24'h6789AB;
        exps[1] = {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, SA, 7'b0000011};
        vals[2] = 24'hCDEFFF;
        exps[2] = {7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0001110, 7'b0001110};
        for (int k = 0; k < 3; k++) begin
            LOAD = 1'b1; VALUE = vals[k];
            tick();
            LOAD = 1'b0;
            tick();
            checks++;
            if (HEX !== exps[k]) begin
                errors++;
                $display("FAIL decode_%h: got %h want %h", vals[k], HEX, exps[k]);
            end
        end
    endtask

    task automatic test_lz();
        logic [7*DIGITS-1:0] exp;
        BLANK_LZ = 1'b1;
        LOAD = 1'b1; VALUE = 24'h000A05;
        tick();
        LOAD = 1'b0;
        tick();
        exp = {BL, BL, BL, SA, S0, S5};
        checks++;
        if (HEX !== exp) begin
            errors++;
            $display("FAIL lz_000a05: got %h want %h", HEX, exp);
        end
        LOAD = 1'b1; VALUE = 24'h000000;
        tick();
        LOAD = 1'b0;
        tick();
        exp = {BL, BL, BL, BL, BL, S0};
        checks++;
        if (HEX !== exp) begin
            errors++;
            $display("FAIL lz_zero: got %h want %h", HEX, exp);
        end
        BLANK_LZ = 1'b0;
    endtask

    task automatic test_blink();
        logic [7*DIGITS-1:0] exp;
        logic                exp_ph;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        BLINK_MASK = 6'b000011;
        LOAD = 1'b1; VALUE = 24'h111111;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) LOAD = 1'b0;
            exp_ph = (k >= 4 && k <= 7);
            checks++;
            if (BLINK_PHASE !== exp_ph) begin
                errors++;
                $display("FAIL blink_phase edge%0d: got %b want %b", k, BLINK_PHASE, exp_ph);
            end
            if (k >= 2) begin
                if (k >= 5 && k <= 8) exp = {S1, S1, S1, S1, BL, BL};
                else                  exp = {S1, S1, S1, S1, S1, S1};
                checks++;
                if (HEX !== exp) begin
                    errors++;
                    $display("FAIL blink_hex edge%0d: got %h want %h", k, HEX, exp);
                end
            end
            // Reload the same value at edge 6; phase edges must not move.
            if (k == 5) LOAD = 1'b1;
            if (k == 6) LOAD = 1'b0;
        end
        BLINK_MASK = '0;
    endtask

    task automatic test_enable();
        logic [7*DIGITS-1:0] exp;
        tick();
        ENABLE = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (HEX !== 42'h3FF_FFFF_FFFF) begin
                errors++;
                $display("FAIL enable_off cyc%0d: got %h want 3ffffffffff", c, HEX);
            end
        end
        ENABLE = 1'b1;
        tick();
        exp = {S1, S1, S1, S1, S1, S1};
        checks++;
        if (HEX !== exp) begin
            errors++;
            $display("FAIL enable_restore: got %h want %h", HEX, exp);
        end
        RESET = 1'b1; LOAD = 1'b1; VALUE = 24'hFFFFFF;
        tick();
        checks++;
        if (HEX !== 42'h3FF_FFFF_FFFF) begin
            errors++;
            $display("FAIL reset_load_edge: got %h want 3ffffffffff", HEX);
        end
        RESET = 1'b0; LOAD = 1'b0;
        tick();
        exp = {S0, S0, S0, S0, S0, S0};
        checks++;
        if (HEX !== exp) begin
            errors++;
            $display("FAIL reset_over_load: got %h want %h", HEX, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp0 [4];
        exp0[0] = S0; exp0[1] = S1; exp0[2] = S2; exp0[3] = S3;
        for (int k = 0; k < 4; k++) begin
            LOAD  = (k < 3);
            VALUE = 24'(k + 1);
            tick();
            checks++;
            if (HEX[6:0] !== exp0[k]) begin
                errors++;
                $display("FAIL b2b_digit0 step%0d: got %b want %b", k, HEX[6:0], exp0[k]);
            end
        end
        LOAD = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_lz();
        test_blink();
        test_enable();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
